gf_div: RTL and testbench

GF_DIV -- requirements
Module: gf_div

---
 rtl/piccolo_gf_pkg.sv | 9 +
 rtl/gf_mul_serial.sv | 32 +++
 rtl/gf_div.sv | 109 ++++++++++
 tb/tb_gf_div.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/piccolo_gf_pkg.sv
// piccolo_gf_pkg: shared GF(2^4) types, field polynomial and FSM states
package piccolo_gf_pkg;
    localparam logic [3:0] POLY_DEFAULT = 4'h3;
    typedef logic [3:0] gf4_t;
    typedef enum logic [2:0] {IDLE, SQ2, SQ4, SQ8, M6, M14, MA, DONE} state_t;
    function automatic gf4_t xtime(input gf4_t a, input gf4_t poly);
        return {a[2:0], 1'b0} ^ (a[3] ? poly : 4'h0);
    endfunction
endpackage

// File: rtl/gf_mul_serial.sv
// gf_mul_serial: 4-cycle bit-serial GF(2^4) shift-add multiplier
module gf_mul_serial import piccolo_gf_pkg::*; #(
    parameter gf4_t POLY = POLY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  gf4_t a_in,
    input  gf4_t b_in,
    output gf4_t product
);
    gf4_t a, b, g;
    // accumulator including the iteration in flight; complete after three steps and stays so after four
    assign product = g ^ (b[0] ? a : 4'h0);
    // load clears the accumulator, step runs one shift-add iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            g <= '0;
        end else if (load) begin
            a <= a_in;
            b <= b_in;
            g <= '0;
        end else if (step) begin
            g <= product;
            a <= xtime(a, POLY);
            b <= b >> 1;
        end
    end
endmodule

// File: rtl/gf_div.sv
// gf_div: sequential GF(2^4) divider, result = A * B^14 via one reused serial multiplier
module gf_div import piccolo_gf_pkg::*; #(
    parameter gf4_t POLY = POLY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       div_zero
);
    state_t     state, state_nx;
    logic [1:0] cnt;
    gf4_t       a_q, b_q, b2, b4, b8, p, prod, op_a, op_b, res_q;
    logic       accept, mul_state, last, load, step, done_q, dz_q;

    assign accept    = state == IDLE && start;
    assign mul_state = state != IDLE && state != DONE;
    assign last      = mul_state && cnt == 2'd3;
    // the fourth iteration of each multiply is taken from product while the next multiply loads
    assign load      = accept || (last && state != MA);
    assign step      = mul_state && !last;
    assign done      = done_q;
    assign result    = res_q;
    assign div_zero  = dz_q;

    gf_mul_serial #(.POLY(POLY)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .a_in    (op_a),
        .b_in    (op_b),
        .product (prod)
    );

    // state register and per-multiply cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= mul_state ? cnt + 2'd1 : 2'd0;
        end
    end

    // next state: zero divisor skips straight to DONE, multiplies advance every fourth cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (B == 4'h0) ? DONE : SQ2;
            DONE:    state_nx = IDLE;
            default: if (cnt == 2'd3) state_nx = state_t'(state + 3'd1);
        endcase
    end

    // outputs: busy flag and operands for the multiply being loaded
    always_comb begin
        busy = state != IDLE;
        op_a = prod;
        op_b = prod;
        case (state)
            IDLE: begin
                op_a = B;
                op_b = B;
            end
            SQ8: begin
                op_a = b2;
                op_b = b4;
            end
            M6:      op_b = b8;
            M14:     op_a = a_q;
            default: ;
        endcase
    end

    // operand latches, intermediate powers and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            b2     <= '0;
            b4     <= '0;
            b8     <= '0;
            p      <= '0;
            res_q  <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == DONE;
            if (accept) begin
                a_q <= A;
                b_q <= B;
            end
            if (last && state == SQ2) b2 <= prod;
            if (last && state == SQ4) b4 <= prod;
            if (last && state == SQ8) b8 <= prod;
            if (last && state == MA) p <= prod;
            if (state == DONE) begin
                res_q <= (b_q == 4'h0) ? 4'h0 : p;
                dz_q  <= b_q == 4'h0;
            end
        end
    end
endmodule

// File: tb/tb_gf_div.sv
// tb_gf_div: randomized self-checking bench for gf_div against a polynomial-arithmetic model
module tb_gf_div;
    logic       clk = 0, rst = 1, start = 0;
    logic [3:0] A = 0, B = 0, result;
    logic       busy, done, div_zero;
    int         checks = 0, failures = 0;

    gf_div #(.POLY(4'h3)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // carry-less product reduced modulo x^4+x+1 by long division
    function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] pr;
        pr = 7'h0;
        for (int i = 0; i < 4; i++) if (y[i]) pr ^= 7'(x) << i;
        for (int i = 6; i >= 4; i--) if (pr[i]) pr ^= 7'h13 << (i - 4);
        return pr[3:0];
    endfunction

    // quotient via brute-force inverse search
    function automatic logic [3:0] ref_div(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] c;
        if (y == 4'h0) return 4'h0;
        for (int i = 1; i < 16; i++) begin
            c = 4'(i);
            if (ref_mul(y, c) == 4'h1) return ref_mul(x, c);
        end
        return 4'hx;
    endfunction

    // one operation: pulse start, scramble inputs and toggle start while busy, wait for done
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat,
                          output logic [3:0] r, output logic dz);
        @(negedge clk);
        A = a; B = b; start = 1;
        @(posedge clk);
        #1;
        start = 0; A = 4'($urandom); B = 4'($urandom);
        lat = -1; r = 4'hx; dz = 1'bx;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k; r = result; dz = div_zero;
                start = 0;
            end else start = 1'($urandom_range(0, 1));
        end
        start = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        if (result !== 4'h0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
        if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        int bad_busy = 0, done_at = -1, extra = 0;
        logic [3:0] r = 4'hx;
        logic dz = 1'bx;
        @(negedge clk);
        A = 5; B = 2; start = 1;
        @(posedge clk);
        #1;
        start = 0; A = 4'hf; B = 4'h0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (busy !== (k < 25)) bad_busy++;
            if (done === 1'b1) begin
                if (done_at < 0) begin done_at = k; r = result; dz = div_zero; end
                else extra++;
            end
        end
        checks += 6;
        if (bad_busy != 0) begin failures++; $display("FAIL basic_busy bad_cycles=%0d want=0", bad_busy); end
        if (done_at != 25) begin failures++; $display("FAIL basic_latency got=%0d want=25", done_at); end
        if (extra != 0) begin failures++; $display("FAIL basic_extra_done got=%0d want=0", extra); end
        if (r !== 4'hb) begin failures++; $display("FAIL basic_result got=%h want=b", r); end
        if (dz !== 1'b0) begin failures++; $display("FAIL basic_div_zero got=%b want=0", dz); end
        if (result !== 4'hb) begin failures++; $display("FAIL basic_hold got=%h want=b", result); end
    endtask

    task automatic test_values();
        logic [3:0] av[3] = '{4'h1, 4'h7, 4'h0};
        logic [3:0] bv[3] = '{4'h3, 4'h7, 4'h6};
        logic [3:0] ev[3] = '{4'he, 4'h1, 4'h0};
        int lat;
        logic [3:0] r;
        logic dz;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat, r, dz);
            checks += 3;
            if (lat != 25) begin failures++; $display("FAIL values_latency a=%h b=%h got=%0d want=25", av[i], bv[i], lat); end
            if (r !== ev[i]) begin failures++; $display("FAIL values_result a=%h b=%h got=%h want=%h", av[i], bv[i], r, ev[i]); end
            if (dz !== 1'b0) begin failures++; $display("FAIL values_div_zero a=%h b=%h got=%b want=0", av[i], bv[i], dz); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [3:0] r;
        logic dz;
        run_op(4'h9, 4'h0, lat, r, dz);
        checks += 3;
        if (lat != 1) begin failures++; $display("FAIL dz_latency got=%0d want=1", lat); end
        if (r !== 4'h0) begin failures++; $display("FAIL dz_result got=%h want=0", r); end
        if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b want=1", dz); end
        run_op(4'h5, 4'h2, lat, r, dz);
        checks += 3;
        if (lat != 25) begin failures++; $display("FAIL dz_after_latency got=%0d want=25", lat); end
        if (r !== 4'hb) begin failures++; $display("FAIL dz_after_result got=%h want=b", r); end
        if (dz !== 1'b0) begin failures++; $display("FAIL dz_after_flag got=%b want=0", dz); end
    endtask

    task automatic test_reset_abort();
        int seen = 0, lat;
        logic [3:0] r;
        logic dz;
        @(negedge clk);
        A = 5; B = 2; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (11) @(posedge clk);
        #2 rst = 1;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
        if (result !== 4'h0) begin failures++; $display("FAIL abort_result got=%h want=0", result); end
        if (div_zero !== 1'b0) begin failures++; $display("FAIL abort_div_zero got=%b want=0", div_zero); end
        #3 rst = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_activity got=%0d want=0", seen); end
        run_op(4'h3, 4'h7, lat, r, dz);
        checks += 2;
        if (lat != 25) begin failures++; $display("FAIL abort_next_latency got=%0d want=25", lat); end
        if (r !== ref_div(4'h3, 4'h7)) begin failures++; $display("FAIL abort_next_result got=%h want=%h", r, ref_div(4'h3, 4'h7)); end
    endtask

    task automatic test_back_to_back();
        int e = 0, nxt_acc = 1, exp_done = -1, ops = 0;
        logic [3:0] la = 0, lb = 0;
        @(negedge clk);
        start = 1;
        while (ops < 6 && e < 400) begin
            A = 4'($urandom);
            B = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            @(posedge clk);
            e++;
            if (e == nxt_acc) begin
                la = A; lb = B;
                exp_done = e + ((lb == 4'h0) ? 1 : 25);
                nxt_acc = exp_done + 1;
            end
            #1;
            checks++;
            if (done !== (e == exp_done)) begin failures++; $display("FAIL b2b_done edge=%0d got=%b want=%b", e, done, e == exp_done); end
            if (e == exp_done) begin
                ops++;
                checks += 2;
                if (result !== ref_div(la, lb)) begin failures++; $display("FAIL b2b_result a=%h b=%h got=%h want=%h", la, lb, result, ref_div(la, lb)); end
                if (div_zero !== (lb == 4'h0)) begin failures++; $display("FAIL b2b_div_zero a=%h b=%h got=%b want=%b", la, lb, div_zero, lb == 4'h0); end
            end
            @(negedge clk);
        end
        start = 0;
        checks++;
        if (ops != 6) begin failures++; $display("FAIL b2b_ops got=%0d want=6", ops); end
        repeat (30) @(posedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] a, b, r;
        logic dz;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            run_op(a, b, lat, r, dz);
            checks += 3;
            if (lat != ((b == 4'h0) ? 1 : 25)) begin failures++; $display("FAIL rand_latency a=%h b=%h got=%0d", a, b, lat); end
            if (r !== ref_div(a, b)) begin failures++; $display("FAIL rand_result a=%h b=%h got=%h want=%h", a, b, r, ref_div(a, b)); end
            if (dz !== (b == 4'h0)) begin failures++; $display("FAIL rand_div_zero a=%h b=%h got=%b want=%b", a, b, dz, b == 4'h0); end
        end
    endtask

    task automatic test_exhaustive();
        int lat;
        logic [3:0] a, b, r;
        logic dz;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            if (b != 4'h0) begin
                run_op(a, b, lat, r, dz);
                checks += 3;
                if (lat != 25) begin failures++; $display("FAIL exh_latency a=%h b=%h got=%0d want=25", a, b, lat); end
                if (ref_mul(b, r) !== a) begin failures++; $display("FAIL exh_inverse a=%h b=%h result=%h b*result=%h want=%h", a, b, r, ref_mul(b, r), a); end
                if (dz !== 1'b0) begin failures++; $display("FAIL exh_div_zero a=%h b=%h got=%b want=0", a, b, dz); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
